// File: rtl/gamectrl_frame_mailbox.sv
// Frame-synchronous mailbox for the Nios II gamecontrol export word: posted words commit on the VGA_VS falling edge.
// Optional frame watchdog enabled by defining GAMECTRL_WDOG_EN.
module gamectrl_frame_mailbox #(
  parameter int DATA_W      = 64,
  parameter int FCNT_W      = 16,
  parameter int OVR_W       = 8,
  parameter int WDOG_FRAMES = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] export_word,
  input  logic              req_toggle,
  input  logic              VGA_VS,
  output logic [DATA_W-1:0] frame_data,
  output logic              ack_toggle,
  output logic              pending,
  output logic [FCNT_W-1:0] frame_count,
  output logic [OVR_W-1:0]  overrun_count,
  output logic              stale
);

  // state      | meaning
  // ST_IDLE    | shadow empty, frame_data is current
  // ST_PENDING | shadow holds a word waiting for the next frame edge
  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_vs_d;
  logic              r_req_seen;
  logic              r_ack;
  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] r_frame;
  logic [FCNT_W-1:0] r_fcnt;
  logic [OVR_W-1:0]  r_ovr;

  logic              w_new_req;
  logic              w_edge;
  logic              w_commit;
  logic              w_ovr_inc;
  logic              w_req_seen_nx;
  logic              w_ack_nx;
  logic [DATA_W-1:0] w_shadow_nx;
  logic [DATA_W-1:0] w_frame_nx;
  logic              w_stale;

  assign w_new_req = (req_toggle != r_req_seen);
  assign w_edge    = r_vs_d & ~VGA_VS;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx    = r_state;
    w_commit      = 1'b0;
    w_ovr_inc     = 1'b0;
    w_req_seen_nx = r_req_seen;
    w_ack_nx      = r_ack;
    w_shadow_nx   = r_shadow;
    w_frame_nx    = r_frame;
    case (r_state)
      ST_IDLE: begin
        if (w_new_req && w_edge) begin
          w_frame_nx    = export_word;
          w_req_seen_nx = req_toggle;
          w_ack_nx      = req_toggle;
          w_commit      = 1'b1;
        end else if (w_new_req) begin
          w_shadow_nx   = export_word;
          w_req_seen_nx = req_toggle;
          w_state_nx    = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // newest word always wins; the displaced shadow word counts as an overrun
        if (w_new_req && w_edge) begin
          w_frame_nx    = export_word;
          w_req_seen_nx = req_toggle;
          w_ack_nx      = req_toggle;
          w_ovr_inc     = 1'b1;
          w_commit      = 1'b1;
          w_state_nx    = ST_IDLE;
        end else if (w_edge) begin
          w_frame_nx    = r_shadow;
          w_ack_nx      = r_req_seen;
          w_commit      = 1'b1;
          w_state_nx    = ST_IDLE;
        end else if (w_new_req) begin
          w_shadow_nx   = export_word;
          w_req_seen_nx = req_toggle;
          w_ovr_inc     = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // A toggle level held through reset is absorbed, not treated as a request.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vs_d     <= 1'b1;
      r_req_seen <= req_toggle;
      r_ack      <= req_toggle;
      r_shadow   <= '0;
      r_frame    <= '0;
      r_fcnt     <= '0;
      r_ovr      <= '0;
    end else begin
      r_vs_d     <= VGA_VS;
      r_req_seen <= w_req_seen_nx;
      r_ack      <= w_ack_nx;
      r_shadow   <= w_shadow_nx;
      r_frame    <= w_frame_nx;
      if (w_edge)
        r_fcnt <= r_fcnt + FCNT_W'(1);
      if (w_ovr_inc && (r_ovr != {OVR_W{1'b1}}))
        r_ovr <= r_ovr + OVR_W'(1);
    end
  end

`ifdef GAMECTRL_WDOG_EN
  localparam int WW = $clog2(WDOG_FRAMES + 1);
  localparam logic [WW-1:0] WMAX = WW'(WDOG_FRAMES);

  logic [WW-1:0] r_wdog;

  always_ff @(posedge Clk) begin
    if (Reset)
      r_wdog <= '0;
    else if (w_commit)
      r_wdog <= '0;
    else if (w_edge && (r_wdog != WMAX))
      r_wdog <= r_wdog + WW'(1);
  end

  assign w_stale = (r_wdog == WMAX);
  // Stale frames disable spell/boss/character; the stored word is left intact.
  assign frame_data = w_stale ? {3'b000, r_frame[DATA_W-4:0]} : r_frame;
`else
  assign w_stale    = 1'b0;
  assign frame_data = r_frame;
`endif

  assign ack_toggle    = r_ack;
  assign pending       = (r_state == ST_PENDING);
  assign frame_count   = r_fcnt;
  assign overrun_count = r_ovr;
  assign stale         = w_stale;

endmodule

// File: tb/tb_gamectrl_frame_mailbox.sv
// Randomized + directed bench for gamectrl_frame_mailbox, checked each cycle against a queue-based mailbox model.
module tb_gamectrl_frame_mailbox;

  localparam int WD = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [63:0] export_word = '0;
  logic        req_toggle = 1'b0;
  logic        VGA_VS = 1'b1;
  logic [63:0] frame_data;
  logic        ack_toggle;
  logic        pending;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;
  logic        stale;

  gamectrl_frame_mailbox #(
    .DATA_W(64), .FCNT_W(16), .OVR_W(8), .WDOG_FRAMES(WD)
  ) dut (
    .Clk(Clk), .Reset(Reset), .export_word(export_word), .req_toggle(req_toggle),
    .VGA_VS(VGA_VS), .frame_data(frame_data), .ack_toggle(ack_toggle), .pending(pending),
    .frame_count(frame_count), .overrun_count(overrun_count), .stale(stale)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // model: words posted since the last commit, newest at the back
  logic [63:0] m_q[$];
  logic [63:0] m_frame;
  logic        m_seen, m_ack, m_vs_prev;
  logic [15:0] m_fcnt;
  logic [7:0]  m_ovr;
  int          m_wd;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    bit edge_now;
    @(posedge Clk);
    if (Reset) begin
      m_q.delete();
      m_frame   = '0;
      m_seen    = req_toggle;
      m_ack     = req_toggle;
      m_vs_prev = 1'b1;
      m_fcnt    = '0;
      m_ovr     = '0;
      m_wd      = 0;
    end else begin
      edge_now  = m_vs_prev && !VGA_VS;
      m_vs_prev = VGA_VS;
      if (req_toggle != m_seen) begin
        if (m_q.size() > 0 && m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
        m_q.push_back(export_word);
        m_seen = req_toggle;
      end
      if (edge_now) begin
        m_fcnt = m_fcnt + 16'd1;
        if (m_q.size() > 0) begin
          m_frame = m_q[m_q.size()-1];
          m_ack   = m_seen;
          m_q.delete();
          m_wd    = 0;
        end else if (m_wd < WD) begin
          m_wd++;
        end
      end
    end
  end

  initial forever begin
    logic [63:0] exp_frame;
    logic        exp_stale;
    @(negedge Clk);
    if (chk_en) begin
      exp_frame = m_frame;
      exp_stale = 1'b0;
`ifdef GAMECTRL_WDOG_EN
      if (m_wd == WD) begin
        exp_stale = 1'b1;
        exp_frame[63:61] = 3'b000;
      end
`endif
      check("frame_data", frame_data, exp_frame);
      check("pending", {63'b0, pending}, {63'b0, (m_q.size() > 0)});
      check("ack_toggle", {63'b0, ack_toggle}, {63'b0, m_ack});
      check("frame_count", {48'b0, frame_count}, {48'b0, m_fcnt});
      check("overrun_count", {56'b0, overrun_count}, {56'b0, m_ovr});
      check("stale", {63'b0, stale}, {63'b0, exp_stale});
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic post(logic [63:0] w);
    export_word = w;
    req_toggle  = ~req_toggle;
    cyc(1);
  endtask

  task automatic vs_edge();
    VGA_VS = 1'b0;
    cyc(1);
    VGA_VS = 1'b1;
    cyc(1);
  endtask

  initial begin
    // toggle level held high through reset is not a request
    Reset = 1'b1; req_toggle = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    Reset = 1'b0;
    cyc(2);
    repeat (3) vs_edge();
    check("s1_frame", frame_data, 64'h0);
    check("s1_pending", {63'b0, pending}, 64'd0);
    check("s1_ack", {63'b0, ack_toggle}, 64'd1);
    check("s1_fcnt", {48'b0, frame_count}, 64'd3);
    check("s1_ovr", {56'b0, overrun_count}, 64'd0);

    // single post mid-frame, committed on the next edge
    Reset = 1'b1; req_toggle = 1'b0;
    cyc(1);
    Reset = 1'b0;
    cyc(3);
    post(64'hA000_0000_0001_2345);
    check("s2_pending_next", {63'b0, pending}, 64'd1);
    check("s2_frame_hold", frame_data, 64'h0);
    cyc(4);
    check("s2_frame_hold2", frame_data, 64'h0);
    VGA_VS = 1'b0;
    cyc(1);
    check("s2_frame_commit", frame_data, 64'hA000_0000_0001_2345);
    check("s2_ack", {63'b0, ack_toggle}, 64'd1);
    check("s2_pending_clr", {63'b0, pending}, 64'd0);
    VGA_VS = 1'b1;
    cyc(2);

    // overrun inside one frame, then saturation
    post(64'h1);
    post(64'h2);
    check("s3_ovr1", {56'b0, overrun_count}, 64'd1);
    vs_edge();
    check("s3_newest_wins", frame_data, 64'h2);
    post(64'h3);
    for (int i = 0; i < 300; i++) post({$urandom, $urandom});
    check("s3_ovr_sat", {56'b0, overrun_count}, 64'hFF);
    vs_edge();
    check("s3_pending_clr", {63'b0, pending}, 64'd0);

    // request and frame edge in the same cycle bypass the shadow
    export_word = 64'h55;
    req_toggle  = ~req_toggle;
    VGA_VS      = 1'b0;
    cyc(1);
    check("s4_bypass_frame", frame_data, 64'h55);
    check("s4_no_pending", {63'b0, pending}, 64'd0);
    check("s4_ovr_same", {56'b0, overrun_count}, 64'hFF);
    check("s4_ack", {63'b0, ack_toggle}, {63'b0, req_toggle});
    VGA_VS = 1'b1;
    cyc(2);

    // reset one cycle before the edge drops the pending word
    post(64'h77);
    check("s5_pending", {63'b0, pending}, 64'd1);
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    VGA_VS = 1'b0;
    cyc(1);
    check("s5_frame", frame_data, 64'h0);
    check("s5_pending", {63'b0, pending}, 64'd0);
    check("s5_ack", {63'b0, ack_toggle}, {63'b0, req_toggle});
    VGA_VS = 1'b1;
    cyc(2);

`ifdef GAMECTRL_WDOG_EN
    post(64'hE000_0000_0000_00FF);
    vs_edge();
    repeat (WD - 1) vs_edge();
    check("wd_not_yet", {63'b0, stale}, 64'd0);
    vs_edge();
    check("wd_stale", {63'b0, stale}, 64'd1);
    check("wd_masked", frame_data, 64'h0000_0000_0000_00FF);
    post(64'hE000_0000_0000_1234);
    VGA_VS = 1'b0;
    cyc(1);
    check("wd_clear", {63'b0, stale}, 64'd0);
    check("wd_new_frame", frame_data, 64'hE000_0000_0000_1234);
    VGA_VS = 1'b1;
    cyc(2);
`else
    repeat (12) vs_edge();
    check("no_wdog_stale", {63'b0, stale}, 64'd0);
`endif

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      Reset       = ($urandom_range(0, 599) == 0);
      export_word = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) req_toggle = ~req_toggle;
      VGA_VS      = ($urandom_range(0, 11) != 0);
      cyc(1);
    end
    Reset  = 1'b0;
    VGA_VS = 1'b1;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
